// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the round-robin register write arbiter.
//   - arb_state_t : transaction phase of the arbiter (IDLE, WRITE, ACK)
//   - DEFAULT_NREQ / DEFAULT_WIDTH : default requester count and data width
//   - MAX_NREQ / IDX_W : largest supported requester count and its index width
//   - onehot_of() : converts a requester index into a one-hot vector
// ---------------------------------------------------------------------------
package reg_arb_pkg;

   localparam int DEFAULT_NREQ  = 4;
   localparam int DEFAULT_WIDTH = 8;

   // Largest requester count the arbiter is meant to handle, and the index
   // width needed to address it.
   localparam int MAX_NREQ = 8;
   localparam int IDX_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } arb_state_t;

   // Returns a MAX_NREQ-wide vector with only bit idx set. Callers slice
   // the low NREQ bits for their own requester count.
   function automatic logic [MAX_NREQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
      logic [MAX_NREQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage : reg_arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority finder. Searches the request vector
// starting at ptr, then ptr+1, ... wrapping modulo NREQ, and reports the
// first requester found.
// Ports:
//   req    [NREQ-1:0]  request vector
//   ptr    [PTR_W-1:0] index with highest priority this round
//   valid              at least one request bit is set
//   winner [PTR_W-1:0] index of the selected requester (0 when !valid)
//   onehot [NREQ-1:0]  one-hot form of winner (all zero when !valid)
// ---------------------------------------------------------------------------
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter int NREQ  = DEFAULT_NREQ,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic             valid,
   output logic [PTR_W-1:0] winner,
   output logic [NREQ-1:0]  onehot
);

   logic [PTR_W:0]      sum;
   logic [PTR_W-1:0]    idx;
   logic [MAX_NREQ-1:0] onehot_full;

   // Walk the requesters in priority order starting at ptr. The sum is one
   // bit wider than the index so ptr+k can be folded back into range with a
   // single subtraction, which also handles non-power-of-two NREQ. Only the
   // first hit is kept, so later set bits never override the winner.
   always_comb begin
      valid       = 1'b0;
      winner      = '0;
      sum         = '0;
      idx         = '0;
      onehot_full = '0;
      onehot      = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NREQ)) begin
            sum = sum - (PTR_W+1)'(NREQ);
         end
         idx = sum[PTR_W-1:0];
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
      if (valid) begin
         onehot_full = onehot_of(IDX_W'(winner));
         onehot      = onehot_full[NREQ-1:0];
      end
   end

endmodule : rr_pick

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// Each transaction takes three edges: the winner is picked and its data
// captured (IDLE->WRITE), the register is written and ack raised
// (WRITE->ACK), then grant/ack/busy drop and the pointer moves past the
// winner (ACK->IDLE). IDLE is always visited between transactions.
// Ports:
//   Clk                     clock, rising edge
//   rst                     asynchronous active-low reset
//   req   [NREQ-1:0]        per-requester write request (level)
//   wdata [NREQ*WIDTH-1:0]  write data, requester i at [i*WIDTH +: WIDTH]
//   gnt   [NREQ-1:0]        registered one-hot grant, zero when idle
//   ack   [NREQ-1:0]        registered one-cycle write-complete pulse
//   busy                    high while a transaction is in flight
//   Q     [WIDTH-1:0]       shared register contents
// ---------------------------------------------------------------------------
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int               NREQ    = DEFAULT_NREQ,
   parameter int               WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                  Clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  busy,
   output logic [WIDTH-1:0]      Q
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t       state;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] win_q;
   logic [WIDTH-1:0] wbuf;

   logic             pick_valid;
   logic [PTR_W-1:0] pick_winner;
   logic [NREQ-1:0]  pick_onehot;

   logic [WIDTH-1:0] wdata_slice [NREQ];

   // Split the flat write-data bus into per-requester words so the winner
   // can select its word with a plain array index.
   for (genvar i = 0; i < NREQ; i++) begin : g_slice
      assign wdata_slice[i] = wdata[i*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .valid  (pick_valid),
      .winner (pick_winner),
      .onehot (pick_onehot)
   );

   // The next search starts just past the current winner, so the winner
   // drops to lowest priority. The explicit wrap keeps this correct when
   // NREQ is not a power of two.
   always_comb begin
      ptr_next = '0;
      if (win_q != PTR_W'(NREQ-1)) begin
         ptr_next = win_q + PTR_W'(1);
      end
   end

   // Transaction sequencer. Data is captured into wbuf when the grant is
   // issued, so later changes on req or wdata cannot disturb the write in
   // progress. The winner index is kept in win_q because req may already
   // have dropped by the time the pointer is advanced. Reset discards any
   // in-flight transaction without writing Q or raising ack.
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
         win_q <= '0;
         wbuf  <= '0;
         gnt   <= '0;
         ack   <= '0;
         busy  <= 1'b0;
         Q     <= RST_VAL;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt   <= pick_onehot;
                  wbuf  <= wdata_slice[pick_winner];
                  win_q <= pick_winner;
                  busy  <= 1'b1;
                  state <= WRITE;
               end
            end
            WRITE: begin
               Q     <= wbuf;
               ack   <= gnt;
               state <= ACK;
            end
            ACK: begin
               ack   <= '0;
               gnt   <= '0;
               busy  <= 1'b0;
               ptr   <= ptr_next;
               state <= IDLE;
            end
            default: begin
               ack   <= '0;
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : reg_write_arbiter
